boot_rom_host_adapter: RTL and testbench

- Sits directly upstream of the boot ROM macro. Converts the SoC host request/response bus (req/gnt, rvalid/rready) into the ROM's single-cycle chip-select/address read port.
- Decodes the ROM window and rejects writes and out-of-range accesses with error responses.
- Buffers responses in a 2-entry FIFO so the host can apply back-pressure.
- Provides a sticky lock that disables all ROM reads after boot.

---
 rtl/boot_rom_host_adapter_pkg.sv | 17 +
 rtl/boot_rom_host_adapter_if.sv | 30 +++
 rtl/boot_rom_host_adapter_rsp_fifo.sv | 67 ++++++
 rtl/boot_rom_host_adapter.sv | 121 ++++++++++++
 tb/tb_boot_rom_host_adapter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/boot_rom_host_adapter_pkg.sv
// Shared definitions for the boot ROM host adapter slice.
//   BOOT_ROM_WIDTH : ROM data width in bits
//   BOOT_ROM_DEPTH : ROM depth in words
//   BOOT_ROM_BASE  : byte base address of the ROM window
//   rsp_t          : one queued host response (error flag + read data)
package boot_rom_pkg;

  localparam int unsigned BOOT_ROM_WIDTH = 32;
  localparam int unsigned BOOT_ROM_DEPTH = 4096;
  localparam logic [31:0] BOOT_ROM_BASE  = 32'h0000_8000;

  typedef struct packed {
    logic                      err;
    logic [BOOT_ROM_WIDTH-1:0] data;
  } rsp_t;

endpackage

// File: rtl/boot_rom_host_adapter_if.sv
// Host request/response bus of the boot ROM adapter.
//   req/gnt      : request handshake, accepted when both are high
//   addr/we      : byte address and write flag of the request
//   rvalid/rready: response handshake
//   rdata/err    : response payload
// master = SoC host side, slave = adapter side.
interface boot_rom_host_adapter_if #(
  parameter int unsigned Width = 32
) ();

  logic             req;
  logic             gnt;
  logic [31:0]      addr;
  logic             we;
  logic             rvalid;
  logic             rready;
  logic [Width-1:0] rdata;
  logic             err;

  modport master (
    output req, addr, we, rready,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, rready,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/boot_rom_host_adapter_rsp_fifo.sv
// Response FIFO of rsp_t entries in front of the host response port.
// Shift-register organisation: entry 0 is the head flop, so the output is
// registered and reads as zero whenever the FIFO is empty.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/push_data_i : enqueue one response
//   pop_i         : dequeue the head (ignored when empty)
//   full_o, empty_o, count_o : occupancy
//   head_o        : current head entry
module boot_rom_rsp_fifo
  import boot_rom_pkg::*;
#(
  parameter int unsigned RspDepth = 2,
  parameter int unsigned CntW     = $clog2(RspDepth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  rsp_t            push_data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o,
  output rsp_t            head_o
);

  localparam int unsigned IdxW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  rsp_t            mem_q [RspDepth];
  logic [CntW-1:0] count_q;
  logic [IdxW-1:0] wr_idx;
  logic            do_pop;
  logic            do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(RspDepth));
  assign count_o = count_q;
  assign head_o  = mem_q[0];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // A same-cycle pop shifts everything down one slot, so the write lands one lower.
  assign wr_idx = IdxW'(do_pop ? count_q - CntW'(1) : count_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      for (int i = 0; i < RspDepth; i++) mem_q[i] <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < RspDepth - 1; i++) mem_q[i] <= mem_q[i+1];
        mem_q[RspDepth-1] <= '0;
      end
      if (do_push) mem_q[wr_idx] <= push_data_i;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_push_when_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o)
  );

endmodule

// File: rtl/boot_rom_host_adapter.sv
// Boot ROM host adapter: turns the host req/gnt + rvalid/rready bus into the
// ROM's single-cycle cs/address read port, decodes the ROM window, answers
// writes, out-of-window and post-lock accesses with error responses, and
// queues responses so the host can back-pressure.
//   clk_i, rst_ni   : clock, async active-low reset
//   host            : host bus (slave modport)
//   lock_i/locked_o : sticky read lock request / state
//   rom_addr_o, rom_cs_o      : ROM read port, combinational in the grant cycle
//   rom_dout_i, rom_dvalid_i  : ROM data, valid the cycle after cs
module boot_rom_host_adapter
  import boot_rom_pkg::*;
#(
  parameter int unsigned Width    = BOOT_ROM_WIDTH,
  parameter int unsigned Depth    = BOOT_ROM_DEPTH,
  parameter int unsigned Aw       = $clog2(Depth),
  parameter logic [31:0] BaseAddr = BOOT_ROM_BASE,
  parameter int unsigned RspDepth = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  boot_rom_host_adapter_if.slave        host,
  input  logic                          lock_i,
  output logic                          locked_o,
  output logic [Aw-1:0]                 rom_addr_o,
  output logic                          rom_cs_o,
  input  logic [Width-1:0]              rom_dout_i,
  input  logic                          rom_dvalid_i
);

  localparam int unsigned CntW        = $clog2(RspDepth + 1);
  localparam logic [31:0] WindowBytes = 32'(Depth * 4);

  logic            locked_q;
  logic            inflight_q;
  logic            inflight_err_q;
  logic [31:0]     offset;
  logic            hit;
  logic            ok;
  logic            gnt;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;
  logic [CntW:0]   outstanding;
  logic [CntW:0]   budget;
  rsp_t            push_rsp;
  rsp_t            head_rsp;

  // A response leaving the FIFO this cycle frees its slot for a new grant.
  assign outstanding = {1'b0, count} + (CntW+1)'(inflight_q);
  assign budget      = (CntW+1)'(RspDepth) + (CntW+1)'(pop);
  assign gnt         = host.req && (outstanding < budget);

  // Unsigned wrap makes addresses below the base fall out of the window too.
  assign offset = host.addr - BaseAddr;
  assign hit    = offset < WindowBytes;
  assign ok     = hit && !host.we && !locked_q;

  assign rom_cs_o   = gnt && ok;
  assign rom_addr_o = rom_cs_o ? offset[Aw+1:2] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_q       <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
    end else begin
      if (lock_i) locked_q <= 1'b1;
      inflight_q     <= gnt;
      inflight_err_q <= gnt && !ok;
    end
  end

  assign push = inflight_q && (inflight_err_q || rom_dvalid_i);

  always_comb begin
    push_rsp      = '0;
    push_rsp.err  = inflight_err_q;
    push_rsp.data = inflight_err_q ? '0 : rom_dout_i;
  end

  assign pop = !empty && host.rready;

  boot_rom_rsp_fifo #(
    .RspDepth (RspDepth),
    .CntW     (CntW)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_rsp),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .head_o      (head_rsp)
  );

  assign host.gnt    = gnt;
  assign host.rvalid = !empty;
  assign host.rdata  = head_rsp.data;
  assign host.err    = head_rsp.err;
  assign locked_o    = locked_q;

  // ROM data without an ok read in flight is dropped (push needs inflight_q).
  a_dvalid_matches_read : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    rom_dvalid_i |-> (inflight_q && !inflight_err_q)
  );

  a_read_returns_data : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (inflight_q && !inflight_err_q) |-> rom_dvalid_i
  );

  a_no_overflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(push && full && !pop)
  );

endmodule

// File: tb/tb_boot_rom_host_adapter.sv
module tb_boot_rom_host_adapter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lock_i = 1'b0;
  logic        locked;
  logic [11:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_dout;
  logic        rom_dvalid;
  logic [31:0] rom_mem [4096];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boot_rom_host_adapter_if #(.Width(32)) host_if ();

  boot_rom_host_adapter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .host         (host_if),
    .lock_i       (lock_i),
    .locked_o     (locked),
    .rom_addr_o   (rom_addr),
    .rom_cs_o     (rom_cs),
    .rom_dout_i   (rom_dout),
    .rom_dvalid_i (rom_dvalid)
  );

  // ROM macro model: one-cycle read, dvalid is a registered copy of cs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_dvalid <= 1'b0;
      rom_dout   <= 32'h0;
    end else begin
      rom_dvalid <= rom_cs;
      rom_dout   <= rom_cs ? rom_mem[rom_addr] : 32'h0;
    end
  end

  // Issues one request with rready=1 and samples grant-cycle and T+1/T+2 outputs.
  task automatic do_access(input logic [31:0] addr, input logic we,
                           output logic g, output logic c, output logic [11:0] a,
                           output logic v1, output logic v2,
                           output logic [31:0] d, output logic e);
    @(negedge clk);
    host_if.req = 1'b1; host_if.addr = addr; host_if.we = we; host_if.rready = 1'b1;
    #1 g = host_if.gnt; c = rom_cs; a = rom_addr;
    @(negedge clk);
    host_if.req = 1'b0; host_if.we = 1'b0;
    #1 v1 = host_if.rvalid;
    @(negedge clk);
    #1 v2 = host_if.rvalid; d = host_if.rdata; e = host_if.err;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (host_if.gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", host_if.gnt); end
    checks++; if (host_if.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", host_if.rvalid); end
    checks++; if (host_if.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", host_if.rdata); end
    checks++; if (host_if.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", host_if.err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (rom_cs !== 1'b0 || rom_addr !== 12'h0) begin errors++; $display("FAIL reset_rom got cs=%b addr=%h want 0/0", rom_cs, rom_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic g, c, v1, v2, e; logic [11:0] a; logic [31:0] d;
    do_access(32'h0000_8010, 1'b0, g, c, a, v1, v2, d, e);
    checks++; if (g !== 1'b1 || c !== 1'b1 || a !== 12'd4) begin errors++; $display("FAIL read_issue got gnt=%b cs=%b addr=%0d want 1/1/4", g, c, a); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL read_early_rvalid got %b want 0", v1); end
    checks++; if (v2 !== 1'b1 || d !== 32'hDEAD_BEEF || e !== 1'b0) begin errors++; $display("FAIL read_rsp got v=%b d=%h e=%b want 1/deadbeef/0", v2, d, e); end
    @(negedge clk);
    #1;
    checks++; if (host_if.rvalid !== 1'b0) begin errors++; $display("FAIL read_drain got %b want 0", host_if.rvalid); end
    // Low address bits are ignored: 0x8013 still reads word 4.
    do_access(32'h0000_8013, 1'b0, g, c, a, v1, v2, d, e);
    checks++; if (c !== 1'b1 || a !== 12'd4 || d !== 32'hDEAD_BEEF || e !== 1'b0) begin errors++; $display("FAIL read_unaligned got cs=%b addr=%0d d=%h e=%b want 1/4/deadbeef/0", c, a, d, e); end
  endtask

  task automatic test_write_and_range();
    logic g, c, v1, v2, e; logic [11:0] a; logic [31:0] d;
    do_access(32'h0000_8000, 1'b1, g, c, a, v1, v2, d, e);
    checks++; if (g !== 1'b1 || c !== 1'b0) begin errors++; $display("FAIL write_issue got gnt=%b cs=%b want 1/0", g, c); end
    checks++; if (v2 !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL write_rsp got v=%b d=%h e=%b want 1/0/1", v2, d, e); end
    do_access(32'h0000_C000, 1'b0, g, c, a, v1, v2, d, e);
    checks++; if (g !== 1'b1 || c !== 1'b0 || v2 !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL range_above got gnt=%b cs=%b v=%b d=%h e=%b want 1/0/1/0/1", g, c, v2, d, e); end
    do_access(32'h0000_7FFC, 1'b0, g, c, a, v1, v2, d, e);
    checks++; if (g !== 1'b1 || c !== 1'b0 || v2 !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL range_below got gnt=%b cs=%b v=%b d=%h e=%b want 1/0/1/0/1", g, c, v2, d, e); end
    do_access(32'h0000_BFFC, 1'b0, g, c, a, v1, v2, d, e);
    checks++; if (c !== 1'b1 || a !== 12'd4095 || d !== 32'h1000_0FFF || e !== 1'b0) begin errors++; $display("FAIL range_last got cs=%b addr=%0d d=%h e=%b want 1/4095/10000fff/0", c, a, d, e); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      host_if.rready = 1'b1; host_if.we = 1'b0;
      host_if.req  = (c < 4);
      host_if.addr = 32'h0000_8000 + 32'(4 * c);
      #1;
      if (c < 4) begin
        checks++; if (host_if.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d got %b want 1", c, host_if.gnt); end
      end
      if (c >= 2 && c < 6) begin
        checks++;
        if (host_if.rvalid !== 1'b1 || host_if.rdata !== 32'h1000_0000 + 32'(c - 2) || host_if.err !== 1'b0) begin
          errors++; $display("FAIL b2b_rsp%0d got v=%b d=%h want 1/%h", c - 2, host_if.rvalid, host_if.rdata, 32'h1000_0000 + 32'(c - 2));
        end
      end
      if (c == 6) begin
        checks++; if (host_if.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", host_if.rvalid); end
      end
    end
  endtask

  task automatic test_back_pressure();
    // Words 8, 9, 10 requested with rready low; only two response slots exist.
    logic [31:0] exp_gnt [8] = '{1, 1, 0, 0, 1, 0, 0, 0};
    logic [31:0] exp_v   [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
    logic [31:0] exp_d   [8] = '{0, 0, 32'h1000_0008, 32'h1000_0008, 32'h1000_0008, 32'h1000_0009, 32'h1000_000A, 0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      host_if.we     = 1'b0;
      host_if.req    = (c < 5);
      host_if.addr   = 32'h0000_8020 + 32'(4 * ((c < 2) ? c : 2));
      host_if.rready = (c >= 4);
      #1;
      if (c < 5) begin
        // The pop in cycle 4 frees a slot in that same cycle, so the third request is granted there.
        checks++; if (host_if.gnt !== exp_gnt[c][0]) begin errors++; $display("FAIL bp_gnt%0d got %b want %b", c, host_if.gnt, exp_gnt[c][0]); end
      end
      checks++;
      if (host_if.rvalid !== exp_v[c][0] || (exp_v[c][0] && (host_if.rdata !== exp_d[c] || host_if.err !== 1'b0))) begin
        errors++; $display("FAIL bp_rsp%0d got v=%b d=%h want %b/%h", c, host_if.rvalid, host_if.rdata, exp_v[c][0], exp_d[c]);
      end
    end
  endtask

  task automatic test_lock();
    logic g, c, v1, v2, e; logic [11:0] a; logic [31:0] d;
    @(negedge clk);
    host_if.req = 1'b1; host_if.addr = 32'h0000_8010; host_if.we = 1'b0; host_if.rready = 1'b1;
    lock_i = 1'b1;
    #1;
    checks++; if (host_if.gnt !== 1'b1 || rom_cs !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL lock_pre got gnt=%b cs=%b locked=%b want 1/1/0", host_if.gnt, rom_cs, locked); end
    @(negedge clk);
    host_if.req = 1'b0; lock_i = 1'b0;
    #1;
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_set got %b want 1", locked); end
    @(negedge clk);
    #1;
    checks++; if (host_if.rvalid !== 1'b1 || host_if.rdata !== 32'hDEAD_BEEF || host_if.err !== 1'b0) begin errors++; $display("FAIL lock_prior_rsp got v=%b d=%h e=%b want 1/deadbeef/0", host_if.rvalid, host_if.rdata, host_if.err); end
    do_access(32'h0000_8010, 1'b0, g, c, a, v1, v2, d, e);
    checks++; if (g !== 1'b1 || c !== 1'b0 || v2 !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL lock_after got gnt=%b cs=%b v=%b d=%h e=%b want 1/0/1/0/1", g, c, v2, d, e); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_sticky got %b want 1", locked); end
  endtask

  task automatic test_reset_mid();
    // Fill to the two-slot limit: one response queued and one in flight.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      host_if.req = 1'b1; host_if.we = 1'b0; host_if.rready = 1'b0;
      host_if.addr = 32'h0000_8000 + 32'(4 * c);
      #1;
    end
    checks++; if (host_if.rvalid !== 1'b1 || host_if.gnt !== 1'b0) begin errors++; $display("FAIL mid_fill got v=%b gnt=%b want 1/0", host_if.rvalid, host_if.gnt); end
    rst_n = 1'b0; host_if.req = 1'b0;
    #1;
    checks++;
    if (host_if.rvalid !== 1'b0 || host_if.rdata !== 32'h0 || host_if.err !== 1'b0 || host_if.gnt !== 1'b0 ||
        locked !== 1'b0 || rom_cs !== 1'b0 || rom_addr !== 12'h0) begin
      errors++; $display("FAIL mid_reset got v=%b d=%h e=%b g=%b l=%b cs=%b a=%h want all 0",
                         host_if.rvalid, host_if.rdata, host_if.err, host_if.gnt, locked, rom_cs, rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; host_if.rready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++; if (host_if.rvalid !== 1'b0) begin errors++; $display("FAIL mid_after%0d got rvalid=%b want 0", c, host_if.rvalid); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 32'h1000_0000 + 32'(i);
    rom_mem[4] = 32'hDEAD_BEEF;
    host_if.req = 1'b0; host_if.addr = 32'h0; host_if.we = 1'b0; host_if.rready = 1'b0;
    test_reset();
    test_single_read();
    test_write_and_range();
    test_back_to_back();
    test_back_pressure();
    test_lock();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
